// File: rtl/atb_sink_pkg.sv
// Shared constants for the ATB trace sink: register map, bit positions, flush states.
package atb_sink_pkg;

  localparam logic [7:0] REG_CTRL      = 8'h00;
  localparam logic [7:0] REG_STATUS    = 8'h04;
  localparam logic [7:0] REG_DATA      = 8'h08;
  localparam logic [7:0] REG_META      = 8'h0C;
  localparam logic [7:0] REG_FILTER    = 8'h10;
  localparam logic [7:0] REG_WATERMARK = 8'h14;
  localparam logic [7:0] REG_BEATS     = 8'h18;
  localparam logic [7:0] REG_TS        = 8'h1C;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_STOP   = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int STAT_EMPTY    = 16;
  localparam int STAT_FULL     = 17;
  localparam int STAT_OVERFLOW = 18;
  localparam int STAT_FLUSH    = 19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } flush_state_e;

endpackage

// File: rtl/trace_sink_fifo.sv
// Circular capture buffer; a push into a full buffer overwrites the oldest entry.
module trace_sink_fifo #(
  parameter int  DEPTH   = 16,
  parameter type entry_t = logic [31:0]
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 wr_entry,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   full_next,
  output logic                   overwrite
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;
  logic            do_pop;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CW'(DEPTH));
  assign do_pop    = pop & ~empty;
  // Pushing into a full buffer with no pop in the same cycle loses the oldest entry.
  assign overwrite = push & full & ~do_pop;
  assign count     = count_reg;
  assign head      = mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    if (push && !do_pop && !full) begin
      count_next = count_reg + 1'b1;
    end else if (do_pop && !push) begin
      count_next = count_reg - 1'b1;
    end
  end

  assign full_next = (count_next == CW'(DEPTH));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      count_reg <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop || overwrite) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_entry;
    end
  end

endmodule

// File: rtl/atb_trace_sink.sv
// ATB trace capture endpoint drained over APB, with flush request handshake.
// Define ATB_SINK_TIMESTAMP_EN to store a cycle timestamp with each beat (TS register).
module atb_trace_sink
  import atb_sink_pkg::*;
#(
  parameter int DATA_LEN       = 32,
  parameter int DEPTH          = 16,
  parameter int APB_ADDR_WIDTH = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [DATA_LEN-1:0]          atdata_i,
  input  logic [$clog2(DATA_LEN)-4:0]  atbytes_i,
  input  logic [6:0]                   atid_i,
  input  logic                         atvalid_i,
  output logic                         atready_o,
  output logic                         afvalid_o,
  input  logic                         afready_i,
  input  logic [APB_ADDR_WIDTH-1:0]    paddr_i,
  input  logic                         pwrite_i,
  input  logic                         psel_i,
  input  logic                         penable_i,
  input  logic [31:0]                  pwdata_i,
  output logic                         pready_o,
  output logic [31:0]                  prdata_o,
  output logic                         irq_o
);

  localparam int BW = $clog2(DATA_LEN) - 3;
  localparam int CW = $clog2(DEPTH) + 1;

  // Entry layout depends on DATA_LEN, so it lives here rather than in the package.
  typedef struct packed {
    logic [DATA_LEN-1:0] data;
    logic [BW-1:0]       bytes;
    logic [6:0]          id;
`ifdef ATB_SINK_TIMESTAMP_EN
    logic [31:0]         ts;
`endif
  } entry_t;

  logic         access, wr_en, rd_en, ctrl_wr;
  logic [7:0]   addr;
  logic         enable_reg, stop_reg, irq_en_reg, overflow_reg;
  logic         enable_next, stop_next;
  logic         filter_en_reg;
  logic [6:0]   filter_id_reg;
  logic [15:0]  watermark_reg;
  logic [31:0]  beats_reg;
  logic         atready_reg, afvalid_reg, irq_reg;
  flush_state_e flush_state_reg;
  logic         flush_busy;
  logic         beat_xfer, fifo_push, fifo_pop;
  entry_t       wr_entry, fifo_head;
  logic [CW-1:0] fifo_count;
  logic [15:0]  count16;
  logic         fifo_full, fifo_empty, fifo_full_next, fifo_overwrite;
  logic [31:0]  head_data32;
  logic [31:0]  rdata;
  logic         unused_bits;

  assign addr     = paddr_i[7:0];
  assign access   = psel_i & penable_i;
  assign wr_en    = access & pwrite_i;
  assign rd_en    = access & ~pwrite_i;
  assign ctrl_wr  = wr_en & (addr == REG_CTRL);
  assign pready_o = access;
  assign prdata_o = rdata;
  assign atready_o = atready_reg;
  assign afvalid_o = afvalid_reg;
  assign irq_o     = irq_reg;
  assign unused_bits = ^{paddr_i[APB_ADDR_WIDTH-1:8], pwdata_i[31:16]};

  assign enable_next = ctrl_wr ? pwdata_i[CTRL_ENABLE] : enable_reg;
  assign stop_next   = ctrl_wr ? pwdata_i[CTRL_STOP]   : stop_reg;
  assign flush_busy  = (flush_state_reg != IDLE);
  assign count16     = 16'(fifo_count);

  // Filtered beats still complete the ATB handshake; they just never reach the buffer.
  assign beat_xfer = atvalid_i & atready_reg;
  assign fifo_push = beat_xfer & (~filter_en_reg | (atid_i == filter_id_reg));
  assign fifo_pop  = rd_en & (addr == REG_DATA);

`ifdef ATB_SINK_TIMESTAMP_EN
  logic [31:0] ts_reg;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ts_reg <= '0;
    else         ts_reg <= ts_reg + 32'd1;
  end
`endif

  always_comb begin
    wr_entry       = '0;
    wr_entry.data  = atdata_i;
    wr_entry.bytes = atbytes_i;
    wr_entry.id    = atid_i;
`ifdef ATB_SINK_TIMESTAMP_EN
    wr_entry.ts    = ts_reg;
`endif
  end

  trace_sink_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .wr_entry  (wr_entry),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .full_next (fifo_full_next),
    .overwrite (fifo_overwrite)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_fit
      if (gi < DATA_LEN) begin : g_bit
        assign head_data32[gi] = fifo_head.data[gi];
      end else begin : g_zero
        assign head_data32[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enable_reg    <= 1'b0;
      stop_reg      <= 1'b0;
      irq_en_reg    <= 1'b0;
      overflow_reg  <= 1'b0;
      filter_en_reg <= 1'b0;
      filter_id_reg <= '0;
      watermark_reg <= '0;
      beats_reg     <= '0;
      atready_reg   <= 1'b0;
      irq_reg       <= 1'b0;
    end else begin
      enable_reg <= enable_next;
      stop_reg   <= stop_next;
      if (ctrl_wr) irq_en_reg <= pwdata_i[CTRL_IRQ_EN];
      if (wr_en && addr == REG_FILTER) begin
        filter_en_reg <= pwdata_i[7];
        filter_id_reg <= pwdata_i[6:0];
      end
      if (wr_en && addr == REG_WATERMARK) watermark_reg <= pwdata_i[15:0];
      if (beat_xfer) beats_reg <= beats_reg + 32'd1;
      if (fifo_overwrite) begin
        overflow_reg <= 1'b1;
      end else if (wr_en && addr == REG_STATUS && pwdata_i[STAT_OVERFLOW]) begin
        overflow_reg <= 1'b0;
      end
      // Look-ahead on next state so ready drops right after the push that fills the buffer.
      atready_reg <= enable_next & (~fifo_full_next | ~stop_next);
      irq_reg     <= irq_en_reg &
                     (((count16 >= watermark_reg) && (watermark_reg != 16'd0)) | overflow_reg);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flush_state_reg <= IDLE;
      afvalid_reg     <= 1'b0;
    end else begin
      case (flush_state_reg)
        IDLE: if (ctrl_wr && pwdata_i[CTRL_FLUSH]) begin
          flush_state_reg <= REQ;
          afvalid_reg     <= 1'b1;
        end
        REQ: if (afready_i) begin
          flush_state_reg <= DONE;
          afvalid_reg     <= 1'b0;
        end
        DONE: flush_state_reg <= IDLE;
        default: begin
          flush_state_reg <= IDLE;
          afvalid_reg     <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (addr)
        REG_CTRL: begin
          rdata[CTRL_ENABLE] = enable_reg;
          rdata[CTRL_FLUSH]  = flush_busy;
          rdata[CTRL_STOP]   = stop_reg;
          rdata[CTRL_IRQ_EN] = irq_en_reg;
        end
        REG_STATUS: begin
          rdata[15:0]          = count16;
          rdata[STAT_EMPTY]    = fifo_empty;
          rdata[STAT_FULL]     = fifo_full;
          rdata[STAT_OVERFLOW] = overflow_reg;
          rdata[STAT_FLUSH]    = flush_busy;
        end
        REG_DATA: if (!fifo_empty) rdata = head_data32;
        REG_META: begin
          rdata[8 +: BW] = fifo_head.bytes;
          rdata[6:0]     = fifo_head.id;
        end
        REG_FILTER: begin
          rdata[7]   = filter_en_reg;
          rdata[6:0] = filter_id_reg;
        end
        REG_WATERMARK: rdata[15:0] = watermark_reg;
        REG_BEATS:     rdata = beats_reg;
`ifdef ATB_SINK_TIMESTAMP_EN
        REG_TS:        rdata = fifo_head.ts;
`endif
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_atb_trace_sink.sv
// Directed self-checking bench for atb_trace_sink (default build, DEPTH=16, DATA_LEN=32).
module tb_atb_trace_sink;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] atdata;
  logic [1:0]  atbytes;
  logic [6:0]  atid;
  logic        atvalid;
  logic        atready;
  logic        afvalid;
  logic        afready;
  logic [31:0] paddr;
  logic        pwrite, psel, penable;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        irq;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  atb_trace_sink #(
    .DATA_LEN       (32),
    .DEPTH          (16),
    .APB_ADDR_WIDTH (32)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .atdata_i  (atdata),
    .atbytes_i (atbytes),
    .atid_i    (atid),
    .atvalid_i (atvalid),
    .atready_o (atready),
    .afvalid_o (afvalid),
    .afready_i (afready),
    .paddr_i   (paddr),
    .pwrite_i  (pwrite),
    .psel_i    (psel),
    .penable_i (penable),
    .pwdata_i  (pwdata),
    .pready_o  (pready),
    .prdata_o  (prdata),
    .irq_o     (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1;
    check("pready_wr", 32'(pready), 32'd1);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    $display("APB WR addr=0x%02h data=0x%08h", a[7:0], d);
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1;
    d = prdata;
    check("pready_rd", 32'(pready), 32'd1);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    $display("APB RD addr=0x%02h data=0x%08h (%s)", a[7:0], d, tag);
    check(tag, d, exp);
  endtask

  task automatic push_beat(input logic [31:0] d, input logic [6:0] id);
    int n;
    atdata = d; atid = id; atbytes = 2'd3; atvalid = 1'b1;
    n = 0;
    while (atready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", 32'(atready), 32'd1);
    @(negedge clk);
    atvalid = 1'b0;
    $display("ATB beat data=0x%08h id=0x%02h", d, id);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; atdata = '0; atbytes = '0; atid = '0; atvalid = 1'b0;
    afready = 1'b0; paddr = '0; pwrite = 1'b0; psel = 1'b0; penable = 1'b0; pwdata = '0;
    repeat (3) @(negedge clk);
    check("rst_atready", 32'(atready), 32'd0);
    check("rst_afvalid", 32'(afvalid), 32'd0);
    check("rst_pready",  32'(pready),  32'd0);
    check("rst_prdata",  prdata,       32'd0);
    check("rst_irq",     32'(irq),     32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic capture and in-order drain
    apb_write(32'h00, 32'h1);
    check("en_ready", 32'(atready), 32'd1);
    push_beat(32'h11111111, 7'h05);
    push_beat(32'h22222222, 7'h05);
    push_beat(32'h33333333, 7'h05);
    read_check("status3", 32'h04, 32'h00000003);
    read_check("beats3",  32'h18, 32'd3);
    read_check("meta",    32'h0C, 32'h00000305);
    read_check("data1",   32'h08, 32'h11111111);
    read_check("data2",   32'h08, 32'h22222222);
    read_check("data3",   32'h08, 32'h33333333);
    read_check("data_empty", 32'h08, 32'h0);
    read_check("status_empty", 32'h04, 32'h00010000);

    // Wrap mode overwrite
    for (int i = 0; i < 18; i++) push_beat(32'(i), 7'h05);
    read_check("wrap_status", 32'h04, 32'h00060010);
    read_check("wrap_first",  32'h08, 32'd2);
    apb_write(32'h04, 32'h00040000);
    read_check("ovf_clear",   32'h04, 32'h0000000F);
    read_check("wrap_beats",  32'h18, 32'd21);
    for (int i = 3; i < 18; i++) read_check("wrap_drain", 32'h08, 32'(i));

    // Stop on full with held beat
    apb_write(32'h00, 32'h5);
    atvalid = 1'b1; atid = 7'h05; atbytes = 2'd3;
    for (int i = 0; i < 16; i++) begin
      atdata = 32'h100 + 32'(i);
      check("stop_ready", 32'(atready), 32'd1);
      @(negedge clk);
    end
    atdata = 32'h1FF;
    check("stop_drop", 32'(atready), 32'd0);
    @(negedge clk);
    check("stop_held", 32'(atready), 32'd0);
    read_check("stop_status", 32'h04, 32'h00020010);
    read_check("stop_pop",    32'h08, 32'h100);
    check("stop_reready", 32'(atready), 32'd1);
    @(negedge clk);
    atvalid = 1'b0;
    check("stop_refull", 32'(atready), 32'd0);
    read_check("stop_status2", 32'h04, 32'h00020010);
    for (int i = 1; i < 16; i++) read_check("stop_drain", 32'h08, 32'h100 + 32'(i));
    read_check("stop_held_data", 32'h08, 32'h1FF);

    // Flush handshake
    apb_write(32'h00, 32'h3);
    check("flush_av0", 32'(afvalid), 32'd1);
    read_check("flush_busy", 32'h00, 32'h3);
    for (int i = 0; i < 3; i++) begin
      check("flush_av", 32'(afvalid), 32'd1);
      @(negedge clk);
    end
    afready = 1'b1;
    check("flush_av_last", 32'(afvalid), 32'd1);
    @(negedge clk);
    afready = 1'b0;
    check("flush_av_drop", 32'(afvalid), 32'd0);
    read_check("flush_status", 32'h04, 32'h00010000);
    read_check("flush_ctrl",   32'h00, 32'h1);

    // ID filter and watermark interrupt
    apb_write(32'h10, 32'h85);
    push_beat(32'hA, 7'h05);
    push_beat(32'hB, 7'h06);
    push_beat(32'hC, 7'h05);
    read_check("filt_status", 32'h04, 32'h00000002);
    read_check("filt_beats",  32'h18, 32'd41);
    read_check("filt_meta",   32'h0C, 32'h00000305);
    apb_write(32'h14, 32'h2);
    @(negedge clk);
    check("irq_off", 32'(irq), 32'd0);
    apb_write(32'h00, 32'h9);
    @(negedge clk);
    check("irq_on", 32'(irq), 32'd1);
    read_check("filt_data", 32'h08, 32'hA);
    @(negedge clk);
    check("irq_below", 32'(irq), 32'd0);

    // Reset mid-flush with beats buffered
    apb_write(32'h10, 32'h0);
    push_beat(32'hD, 7'h06);
    push_beat(32'hE, 7'h05);
    push_beat(32'hF, 7'h05);
    read_check("pre_rst_status", 32'h04, 32'h00000004);
    apb_write(32'h00, 32'h3);
    check("pre_rst_av", 32'(afvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_afvalid", 32'(afvalid), 32'd0);
    check("rst_mid_atready", 32'(atready), 32'd0);
    check("rst_mid_irq",     32'(irq),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_check("post_rst_status", 32'h04, 32'h00010000);
    read_check("post_rst_ctrl",   32'h00, 32'h0);
    apb_write(32'h18, 32'h1234);
    read_check("ro_beats",  32'h18, 32'h0);
    read_check("unmapped",  32'h20, 32'h0);
`ifndef ATB_SINK_TIMESTAMP_EN
    read_check("ts_absent", 32'h1C, 32'h0);
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
